sipo_deser: RTL and testbench

Serial-in, parallel-out deserializer that receives framed bit streams from the serial shift-register chain and presents each completed word on a valid/ready parallel port. Each frame carries one bit per clock: a start bit (0), WIDTH data bits LSB-first, and a stop bit (1). The block sits at the receiving end of a serial link, between the serial line and any parallel consumer. It checks framing, holds one completed word, and flags words dropped because the consumer was not ready.

---
 rtl/sipo_pkg.sv | 7 +
 rtl/sipo_shift.sv | 14 +
 rtl/sipo_deser.sv | 58 +++++
 tb/tb_sipo_deser.sv | 101 ++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared state encoding and line levels for the SIPO deserializer
package sipo_pkg;
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/sipo_shift.sv
// sipo_shift: right-shift register, serial bits enter at the MSB end
module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             si,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en) q <= {si, q[WIDTH-1:1]};
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: framed serial receiver with one-word holding register and error flags
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  output logic [WIDTH-1:0] pdata,
  output logic             pvalid,
  input  logic             pready,
  output logic             frame_err,
  output logic             overrun
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sq;
  logic en, last, good, load, fe_n, ov_n;
  sipo_shift #(.WIDTH(WIDTH)) u_shift (
    .clk(clk),
    .rst(rst),
    .en (en),
    .si (si),
    .q  (sq)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    last    = cnt == CW'(WIDTH - 1);
    state_n = state == IDLE ? (si == START_BIT ? DATA : IDLE) :
              state == DATA ? (last ? STOP : DATA) : IDLE;
  end
  always_comb begin
    en   = state == DATA;
    good = si == STOP_BIT;
    load = state == STOP && good && (!pvalid || pready);
    ov_n = state == STOP && good && pvalid && !pready;
    fe_n = state == STOP && !good;
  end
  // a load on the same edge as a handshake keeps pvalid high with the new word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt       <= '0;
      pdata     <= '0;
      pvalid    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cnt       <= en ? cnt + CW'(1) : '0;
      pdata     <= load ? sq : pdata;
      pvalid    <= load | (pvalid & ~pready);
      frame_err <= fe_n;
      overrun   <= ov_n;
    end
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed frames against hand-computed words and flag pulses
module tb_sipo_deser;
  import sipo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic si = IDLE_LEVEL;
  logic pready = 1'b0;
  logic [7:0] pdata;
  logic pvalid, frame_err, overrun;
  int n_chk = 0;
  int n_pass = 0;
  logic any_hi;
  sipo_deser #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .si       (si),
    .pdata    (pdata),
    .pvalid   (pvalid),
    .pready   (pready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic bit_edge(input logic b, input logic pr);
    si = b;
    pready = pr;
    @(posedge clk);
    #1;
  endtask
  task automatic send_data(input logic [7:0] d);
    for (int i = 0; i < 8; i++) bit_edge(d[i], 1'b0);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pr);
    bit_edge(START_BIT, 1'b0);
    send_data(d);
    bit_edge(stop, pr);
  endtask
  initial begin
    #12 rst = 1'b0;
    chk("reset_pdata", pdata, 8'h00);
    chk("reset_pvalid", pvalid, 1'b0);
    any_hi = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bit_edge(IDLE_LEVEL, 1'b0);
      any_hi |= pvalid | frame_err | overrun;
    end
    chk("idle_flags", any_hi, 1'b0);
    chk("idle_pdata", pdata, 8'h00);
    send_frame(8'hA5, STOP_BIT, 1'b0);
    chk("a5_pvalid", pvalid, 1'b1);
    chk("a5_pdata", pdata, 8'hA5);
    chk("a5_flags", {frame_err, overrun}, 2'b00);
    for (int i = 0; i < 3; i++) bit_edge(IDLE_LEVEL, 1'b0);
    chk("a5_hold", {pvalid, pdata}, {1'b1, 8'hA5});
    bit_edge(IDLE_LEVEL, 1'b1);
    chk("a5_consumed", pvalid, 1'b0);
    send_frame(8'h3C, STOP_BIT, 1'b0);
    chk("b2b_first", {pvalid, pdata}, {1'b1, 8'h3C});
    send_frame(8'hC3, STOP_BIT, 1'b0);
    chk("ovr_pulse", overrun, 1'b1);
    chk("ovr_keep", {pvalid, pdata}, {1'b1, 8'h3C});
    chk("ovr_no_ferr", frame_err, 1'b0);
    bit_edge(IDLE_LEVEL, 1'b0);
    chk("ovr_one_cycle", overrun, 1'b0);
    bit_edge(IDLE_LEVEL, 1'b1);
    chk("ovr_consumed", pvalid, 1'b0);
    send_frame(8'h3C, STOP_BIT, 1'b0);
    chk("hs_first", {pvalid, pdata}, {1'b1, 8'h3C});
    send_frame(8'hC3, STOP_BIT, 1'b1);
    chk("hs_load", {pvalid, pdata}, {1'b1, 8'hC3});
    chk("hs_no_ovr", overrun, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    chk("ferr_pulse", frame_err, 1'b1);
    chk("ferr_no_ovr", overrun, 1'b0);
    chk("ferr_keep", {pvalid, pdata}, {1'b1, 8'hC3});
    bit_edge(START_BIT, 1'b0);
    chk("ferr_one_cycle", frame_err, 1'b0);
    send_data(8'h12);
    bit_edge(STOP_BIT, 1'b1);
    chk("after_ferr", {pvalid, pdata}, {1'b1, 8'h12});
    chk("after_ferr_flags", {frame_err, overrun}, 2'b00);
    bit_edge(START_BIT, 1'b0);
    for (int i = 0; i < 4; i++) bit_edge(1'b1, 1'b0);
    si = IDLE_LEVEL;
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {pvalid, pdata, frame_err, overrun}, 11'h0);
    #3 rst = 1'b0;
    bit_edge(IDLE_LEVEL, 1'b0);
    chk("rst_no_pulse", {pvalid, frame_err, overrun}, 3'b000);
    send_frame(8'hFF, STOP_BIT, 1'b0);
    chk("post_rst_frame", {pvalid, pdata}, {1'b1, 8'hFF});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
